// File: rtl/bist_response_analyzer.sv
// BIST output response analyzer: compacts CUT responses into a MISR and checks
// signature/cycle count against golden values. Optional ORA_STICKY_FAIL_EN adds fail_sticky.
module bist_response_analyzer #(
  parameter int                RESP_W     = 4,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] POLY       = 16'h1021,
  parameter logic [MISR_W-1:0] SEED       = 16'h0000,
  parameter logic [MISR_W-1:0] GOLDEN     = 16'h0000,
  parameter int                CNT_W      = 16,
  parameter int                EXP_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              running,
  input  logic              bist_end,
  input  logic [RESP_W-1:0] resp,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  cycles,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              aborted
`ifdef ORA_STICKY_FAIL_EN
  ,
  output logic              fail_sticky
`endif
);

  // state   | meaning
  // IDLE    | waiting for running; stale bist_end ignored
  // COMPACT | folding resp into MISR every running cycle
  // COMPARE | one cycle: judge signature and count
  // DONE    | result held until next session or reset
  typedef enum logic [1:0] {S_IDLE, S_COMPACT, S_COMPARE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [MISR_W-1:0] r_misr, w_misr_nxt;
  logic [CNT_W-1:0]  r_cycles, w_cycles_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic              r_fail, w_fail_nxt;
  logic              r_aborted, w_aborted_nxt;
  logic              w_match;
  logic [CNT_W-1:0]  w_cycles_inc;
`ifdef ORA_STICKY_FAIL_EN
  logic              r_sticky, w_sticky_nxt;
`endif

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [RESP_W-1:0] r);
    logic [MISR_W-1:0] ext;
    ext = '0;
    ext[RESP_W-1:0] = r;
    return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? POLY : '0) ^ ext;
  endfunction

  assign w_match      = (r_misr == GOLDEN) && (r_cycles == CNT_W'(EXP_CYCLES));
  assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_misr_nxt    = r_misr;
    w_cycles_nxt  = r_cycles;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_aborted_nxt = 1'b0;
`ifdef ORA_STICKY_FAIL_EN
    w_sticky_nxt  = r_sticky;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (running) begin
          w_misr_nxt   = misr_step(SEED, resp);
          w_cycles_nxt = CNT_W'(1);
          w_done_nxt   = 1'b0;
          w_pass_nxt   = 1'b0;
          w_fail_nxt   = 1'b0;
          w_state_nxt  = S_COMPACT;
        end
      end
      S_COMPACT: begin
        if (running) begin
          w_misr_nxt   = misr_step(r_misr, resp);
          w_cycles_nxt = w_cycles_inc;
        end
        if (bist_end) begin
          w_state_nxt = S_COMPARE;
        end else if (!running) begin
          // abort: MISR and count stay frozen for debug
          w_aborted_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
`ifdef ORA_STICKY_FAIL_EN
          w_sticky_nxt  = 1'b1;
`endif
        end
      end
      S_COMPARE: begin
        w_done_nxt  = 1'b1;
        w_pass_nxt  = w_match;
        w_fail_nxt  = !w_match;
        w_state_nxt = S_DONE;
`ifdef ORA_STICKY_FAIL_EN
        if (!w_match) w_sticky_nxt = 1'b1;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_misr    <= SEED;
      r_cycles  <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_aborted <= 1'b0;
`ifdef ORA_STICKY_FAIL_EN
      r_sticky  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_misr    <= w_misr_nxt;
      r_cycles  <= w_cycles_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_aborted <= w_aborted_nxt;
`ifdef ORA_STICKY_FAIL_EN
      r_sticky  <= w_sticky_nxt;
`endif
    end
  end

  assign signature = r_misr;
  assign cycles    = r_cycles;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign aborted   = r_aborted;
`ifdef ORA_STICKY_FAIL_EN
  assign fail_sticky = r_sticky;
`endif

endmodule
